scaler_chain: RTL and testbench

SCALER_CHAIN -- requirements
Module: scaler_chain

---
 rtl/scaler_pkg.sv | 32 +++
 rtl/scaler_chan_rd.sv | 51 +++++
 rtl/scaler_chain.sv | 132 +++++++++++++
 tb/tb_scaler_chain.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/scaler_pkg.sv
// Shared constants and the field-extract helper for the scaler chain.
// Latency: none (package only).
// Backpressure: none (package only).
package scaler_pkg;

    localparam int STAGES_DEF  = 33;
    localparam int CH_W_DEF    = 14;
    localparam int CHA_LSB_DEF = 19;
    localparam int CHB_LSB_DEF = 5;

    // Widest counter the extract helper can handle.
    localparam int MAXW = 64;

    // Pull w bits starting at bit lsb out of an n-bit counter.
    // Bits that would lie above the top stage read as zero.
    function automatic logic [MAXW-1:0] field_extract(
        input logic [MAXW-1:0] v,
        input int              lsb,
        input int              w,
        input int              n
    );
        logic [MAXW-1:0] r;
        r = '0;
        for (int i = 0; i < MAXW; i++) begin
            if ((i < w) && (lsb + i < n)) begin
                r[i] = v[lsb + i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/scaler_chan_rd.sv
// One channel read port: field select, data register and one-cycle valid.
// Latency: 1 cycle from the rising edge of rd to vld/dat.
// Backpressure: none; a held rd produces a single read, data holds until the next.
module scaler_chan_rd
    import scaler_pkg::*;
#(
    parameter int N    = STAGES_DEF - 1,
    parameter int CH_W = CH_W_DEF,
    parameter int LSB  = CHA_LSB_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    cnt,
    input  logic            rd,
    input  logic            ovr,
    input  logic [CH_W-1:0] ovr_dat,
    output logic [CH_W-1:0] dat,
    output logic            vld
);

    // Stage numbers start at 2, so stage s lives in counter bit s-2.
    if (LSB < 2) begin : g_bad_lsb
        $error("scaler_chan_rd: field LSB stage must be 2 or higher");
    end
    if (N > MAXW) begin : g_bad_width
        $error("scaler_chan_rd: counter wider than field_extract supports");
    end

    logic            rd_q;
    logic            fire;
    logic [CH_W-1:0] fld;

    assign fld  = CH_W'(field_extract(MAXW'(cnt), LSB - 2, CH_W, N));
    assign fire = rd & ~rd_q;

    // Capture the field on the first cycle of a request; valid lasts one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= 1'b0;
            dat  <= '0;
            vld  <= 1'b0;
        end else begin
            rd_q <= rd;
            vld  <= fire;
            if (fire) begin
                dat <= ovr ? ovr_dat : fld;
            end
        end
    end

endmodule

// File: rtl/scaler_chain.sv
// Binary scaler chain (stages 2..STAGES) with rise/fall pulses and two read channels.
// Latency: fs updates 1 cycle after adv/load; pulses and read data 1 cycle after the edge.
// Backpressure: none; optional coherent A/B snapshot when SCALER_SNAPSHOT_EN is defined.
module scaler_chain
    import scaler_pkg::*;
#(
    parameter int STAGES  = STAGES_DEF,
    parameter int CH_W    = CH_W_DEF,
    parameter int CHA_LSB = CHA_LSB_DEF,
    parameter int CHB_LSB = CHB_LSB_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              adv,
    input  logic              load,
    input  logic [STAGES-2:0] load_val,
    input  logic              rd_a,
    input  logic              rd_b,
    output logic [STAGES-2:0] fs,
    output logic [STAGES-2:0] fa,
    output logic [STAGES-2:0] fb,
    output logic              wrap,
    output logic [CH_W-1:0]   ch_a,
    output logic [CH_W-1:0]   ch_b,
    output logic              ch_a_vld,
    output logic              ch_b_vld
);

    localparam int            N   = STAGES - 1;
    localparam logic [N-1:0]  ONE = N'(1);

    logic [N-1:0] cnt;
    logic [N-1:0] nxt;

    assign nxt = cnt + ONE;
    assign fs  = cnt;

    // Counter with load priority; edge pulses come only from increments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            fa   <= '0;
            fb   <= '0;
            wrap <= 1'b0;
        end else if (load) begin
            cnt  <= load_val;
            fa   <= '0;
            fb   <= '0;
            wrap <= 1'b0;
        end else if (adv) begin
            cnt  <= nxt;
            fa   <= nxt & ~cnt;
            fb   <= cnt & ~nxt;
            wrap <= &cnt;
        end else begin
            fa   <= '0;
            fb   <= '0;
            wrap <= 1'b0;
        end
    end

    logic            ovr_b;
    logic [CH_W-1:0] ovr_b_dat;

`ifdef SCALER_SNAPSHOT_EN
    logic            rda_q;
    logic            rdb_q;
    logic            shv;
    logic [CH_W-1:0] shadow;
    logic            fire_a;
    logic            fire_b;

    assign fire_a    = rd_a & ~rda_q;
    assign fire_b    = rd_b & ~rdb_q;
    // A simultaneous A+B read is already coherent, so it bypasses the shadow.
    assign ovr_b     = shv & ~fire_a;
    assign ovr_b_dat = shadow;

    // A read snapshots the B field; the next B read consumes that snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rda_q  <= 1'b0;
            rdb_q  <= 1'b0;
            shv    <= 1'b0;
            shadow <= '0;
        end else begin
            rda_q <= rd_a;
            rdb_q <= rd_b;
            if (fire_a) begin
                shadow <= CH_W'(field_extract(MAXW'(cnt), CHB_LSB - 2, CH_W, N));
                shv    <= ~fire_b;
            end else if (fire_b) begin
                shv <= 1'b0;
            end
        end
    end
`else
    assign ovr_b     = 1'b0;
    assign ovr_b_dat = '0;
`endif

    scaler_chan_rd #(
        .N    (N),
        .CH_W (CH_W),
        .LSB  (CHA_LSB)
    ) u_rd_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .cnt     (cnt),
        .rd      (rd_a),
        .ovr     (1'b0),
        .ovr_dat ({CH_W{1'b0}}),
        .dat     (ch_a),
        .vld     (ch_a_vld)
    );

    scaler_chan_rd #(
        .N    (N),
        .CH_W (CH_W),
        .LSB  (CHB_LSB)
    ) u_rd_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .cnt     (cnt),
        .rd      (rd_b),
        .ovr     (ovr_b),
        .ovr_dat (ovr_b_dat),
        .dat     (ch_b),
        .vld     (ch_b_vld)
    );

endmodule

// File: tb/tb_scaler_chain.sv
// Directed bench for scaler_chain with a read-data scoreboard.
// Latency: checks read data one cycle after each request.
// Backpressure: none.
module tb_scaler_chain;

    localparam int N    = 32;
    localparam int CH_W = 14;

    logic            clk;
    logic            rst_n;
    logic            adv;
    logic            load;
    logic [N-1:0]    load_val;
    logic            rd_a;
    logic            rd_b;
    logic [N-1:0]    fs;
    logic [N-1:0]    fa;
    logic [N-1:0]    fb;
    logic            wrap;
    logic [CH_W-1:0] ch_a;
    logic [CH_W-1:0] ch_b;
    logic            ch_a_vld;
    logic            ch_b_vld;

    int checks   = 0;
    int failures = 0;

    logic [CH_W-1:0] qa[$];
    logic [CH_W-1:0] qb[$];

    scaler_chain dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .adv      (adv),
        .load     (load),
        .load_val (load_val),
        .rd_a     (rd_a),
        .rd_b     (rd_b),
        .fs       (fs),
        .fa       (fa),
        .fb       (fb),
        .wrap     (wrap),
        .ch_a     (ch_a),
        .ch_b     (ch_b),
        .ch_a_vld (ch_a_vld),
        .ch_b_vld (ch_b_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pulses(input string name, input logic [N-1:0] efa,
                              input logic [N-1:0] efb, input logic ewrap);
        chk({name, ".fa"},   64'(fa),   64'(efa));
        chk({name, ".fb"},   64'(fb),   64'(efb));
        chk({name, ".wrap"}, 64'(wrap), 64'(ewrap));
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, ".fs"}, 64'(fs), 64'd0);
        chk_pulses(name, '0, '0, 1'b0);
        chk({name, ".ch_a"},     64'(ch_a),     64'd0);
        chk({name, ".ch_b"},     64'(ch_b),     64'd0);
        chk({name, ".ch_a_vld"}, 64'(ch_a_vld), 64'd0);
        chk({name, ".ch_b_vld"}, 64'(ch_b_vld), 64'd0);
    endtask

    // Monitor: every valid read must match the oldest expected value.
    always @(posedge clk) begin
        #1;
        if (ch_a_vld) begin
            if (qa.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL ch_a_vld: unexpected valid, data 0x%0h at %0t", ch_a, $time);
            end else begin
                chk("ch_a", 64'(ch_a), 64'(qa.pop_front()));
            end
        end
        if (ch_b_vld) begin
            if (qb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL ch_b_vld: unexpected valid, data 0x%0h at %0t", ch_b, $time);
            end else begin
                chk("ch_b", 64'(ch_b), 64'(qb.pop_front()));
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        adv      = 1'b0;
        load     = 1'b0;
        load_val = '0;
        rd_a     = 1'b0;
        rd_b     = 1'b0;
        #3;
        chk_all_zero("reset");
        step();
        step();
        rst_n = 1'b1;

        // Eight increments from zero: 7 -> 8 raises stage 5 and drops stages 2..4.
        adv = 1'b1;
        step();
        chk("inc1.fs", 64'(fs), 64'd1);
        chk_pulses("inc1", 32'h1, 32'h0, 1'b0);
        for (int i = 0; i < 7; i++) step();
        adv = 1'b0;
        chk("inc8.fs", 64'(fs), 64'd8);
        chk_pulses("inc8", 32'h8, 32'h7, 1'b0);
        step();
        chk_pulses("idle", 32'h0, 32'h0, 1'b0);

        // Preset to all ones (no pulses), then roll over.
        load     = 1'b1;
        load_val = '1;
        step();
        load = 1'b0;
        chk("ld1.fs", 64'(fs), 64'hFFFF_FFFF);
        chk_pulses("ld1", 32'h0, 32'h0, 1'b0);
        adv = 1'b1;
        step();
        adv = 1'b0;
        chk("wrap.fs", 64'(fs), 64'd0);
        chk_pulses("wrap", 32'h0, 32'hFFFF_FFFF, 1'b1);
        step();
        chk_pulses("post_wrap", 32'h0, 32'h0, 1'b0);

        // Load wins over adv on the same edge.
        load     = 1'b1;
        adv      = 1'b1;
        load_val = 32'd5;
        step();
        load = 1'b0;
        adv  = 1'b0;
        chk("ld_adv.fs", 64'(fs), 64'd5);
        chk_pulses("ld_adv", 32'h0, 32'h0, 1'b0);

        // Stage 32 set (counter bit 30): A field bit 13, read pre-increment.
        load     = 1'b1;
        load_val = 32'h4000_0000;
        step();
        load = 1'b0;
        rd_a = 1'b1;
        adv  = 1'b1;
        qa.push_back(14'h2000);
        step();
        rd_a = 1'b0;
        adv  = 1'b0;
        chk("rda_adv.fs", 64'(fs), 64'h4000_0001);
        step();
        chk("ch_a_hold", 64'(ch_a), 64'h2000);

        // Both channels in one edge use the same pre-increment value.
        // 0x12345678: bits 30..17 = 0x091A, bits 16..3 = 0x0ACF.
        load     = 1'b1;
        load_val = 32'h1234_5678;
        step();
        load = 1'b0;
        rd_a = 1'b1;
        rd_b = 1'b1;
        adv  = 1'b1;
        qa.push_back(14'h091A);
        qb.push_back(14'h0ACF);
        step();
        rd_a = 1'b0;
        rd_b = 1'b0;
        adv  = 1'b0;
        step();

        // A request held for three cycles yields one read (counter 0x12345679).
        rd_a = 1'b1;
        qa.push_back(14'h091A);
        step();
        step();
        step();
        rd_a = 1'b0;
        step();

        // Stages 5 and 6 set (counter 0x18): B field 0x3. After 100 advances the
        // counter is 0x7C, whose live B field is 0xF.
        load     = 1'b1;
        load_val = 32'h18;
        step();
        load = 1'b0;
        rd_a = 1'b1;
        qa.push_back(14'h0);
        step();
        rd_a = 1'b0;
        adv  = 1'b1;
        for (int i = 0; i < 100; i++) step();
        adv = 1'b0;
        chk("snap.fs", 64'(fs), 64'h7C);
        rd_b = 1'b1;
`ifdef SCALER_SNAPSHOT_EN
        qb.push_back(14'h3);
`else
        qb.push_back(14'hF);
`endif
        step();
        rd_b = 1'b0;
        step();
        rd_b = 1'b1;
        qb.push_back(14'hF);
        step();
        rd_b = 1'b0;
        step();

        // Get nonzero state everywhere, then reset in the middle of a request.
        load     = 1'b1;
        load_val = 32'h4000_0000;
        step();
        load = 1'b0;
        rd_a = 1'b1;
        rd_b = 1'b1;
        adv  = 1'b1;
        qa.push_back(14'h2000);
        qb.push_back(14'h0);
        step();
        rd_a = 1'b0;
        rd_b = 1'b0;
        chk("pre_rst.fa", 64'(fa), 64'h1);
        rd_a = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        step();
        rd_a = 1'b0;
        adv  = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("rel.ch_a_vld", 64'(ch_a_vld), 64'd0);
        chk_pulses("rel", 32'h0, 32'h0, 1'b0);
        step();
        chk("rel2.ch_a_vld", 64'(ch_a_vld), 64'd0);

        step();
        step();
        chk("qa_empty", 64'(qa.size()), 64'd0);
        chk("qb_empty", 64'(qb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
